// File: rtl/port2_read_scheduler.sv
// Arbiter for shared read-only memory port 2: VGA has priority, audio is
// protected from starvation by a bounded-wait override. Read tags track latency.
module port2_read_scheduler #(
  parameter int ADDR_W     = 18,
  parameter int DATA_W     = 16,
  parameter int RD_LATENCY = 1,
  parameter int MAX_WAIT   = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vga_req,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic              vga_gnt,
  output logic              vga_rd_valid,
  output logic [DATA_W-1:0] vga_rd_data,
  input  logic              aud_req,
  input  logic [ADDR_W-1:0] aud_addr,
  output logic              aud_gnt,
  output logic              aud_rd_valid,
  output logic [DATA_W-1:0] aud_rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              aud_forced
);

  localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

  logic [7:0]            wait_cnt;
  logic [ADDR_W-1:0]     last_addr;
  logic                  force_aud;
  logic                  any_gnt;
  logic [RD_LATENCY-1:0] tag_valid;
  logic [RD_LATENCY-1:0] tag_src;

  // Grants are masked by reset_n so nothing is accepted while in reset.
  always_comb begin
    force_aud = reset_n && aud_req && (wait_cnt == MAX_WAIT_C);
    aud_gnt   = reset_n && aud_req && (!vga_req || force_aud);
    vga_gnt   = reset_n && vga_req && !aud_gnt;
    any_gnt   = vga_gnt || aud_gnt;
    if (aud_gnt)
      mem_addr = aud_addr;
    else if (vga_gnt)
      mem_addr = vga_addr;
    else
      mem_addr = last_addr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt   <= '0;
      last_addr  <= '0;
      aud_forced <= 1'b0;
    end else begin
      if (aud_req && !aud_gnt) begin
        if (wait_cnt != MAX_WAIT_C)
          wait_cnt <= wait_cnt + 8'd1;
      end else begin
        wait_cnt <= '0;
      end
      if (any_gnt)
        last_addr <= mem_addr;
      aud_forced <= force_aud;
    end
  end

  // Tag shift register: stage RD_LATENCY-1 lines up with data on mem_rd_data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_valid <= '0;
      tag_src   <= '0;
    end else begin
      tag_valid[0] <= any_gnt;
      tag_src[0]   <= aud_gnt;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_src[i]   <= tag_src[i-1];
      end
    end
  end

  assign vga_rd_valid = tag_valid[RD_LATENCY-1] && !tag_src[RD_LATENCY-1];
  assign aud_rd_valid = tag_valid[RD_LATENCY-1] &&  tag_src[RD_LATENCY-1];
  assign vga_rd_data  = mem_rd_data;
  assign aud_rd_data  = mem_rd_data;

endmodule

// File: tb/tb_port2_read_scheduler.sv
// Directed bench: three schedulers (RD_LATENCY 1, 2, 3) share one stimulus,
// each fed by its own model RAM with matching read latency.
module tb_port2_read_scheduler;

  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              vga_req, aud_req;
  logic [ADDR_W-1:0] vga_addr, aud_addr;

  logic              vga_gnt_1, vga_rd_valid_1, aud_gnt_1, aud_rd_valid_1, aud_forced_1;
  logic              vga_gnt_2, vga_rd_valid_2, aud_gnt_2, aud_rd_valid_2, aud_forced_2;
  logic              vga_gnt_3, vga_rd_valid_3, aud_gnt_3, aud_rd_valid_3, aud_forced_3;
  logic [DATA_W-1:0] vga_rd_data_1, aud_rd_data_1, mem_rd_data_1;
  logic [DATA_W-1:0] vga_rd_data_2, aud_rd_data_2, mem_rd_data_2;
  logic [DATA_W-1:0] vga_rd_data_3, aud_rd_data_3, mem_rd_data_3;
  logic [ADDR_W-1:0] mem_addr_1, mem_addr_2, mem_addr_3;

  logic [ADDR_W-1:0] apipe_1 [1];
  logic [ADDR_W-1:0] apipe_2 [2];
  logic [ADDR_W-1:0] apipe_3 [3];

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] ram_word(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ 16'hA5C3;
  endfunction

  // Model RAMs: address captured at each edge, data appears RD_LATENCY cycles on.
  always @(posedge clk) begin
    apipe_1[0] <= mem_addr_1;
    apipe_2[0] <= mem_addr_2;
    apipe_2[1] <= apipe_2[0];
    apipe_3[0] <= mem_addr_3;
    apipe_3[1] <= apipe_3[0];
    apipe_3[2] <= apipe_3[1];
  end

  assign mem_rd_data_1 = ram_word(apipe_1[0]);
  assign mem_rd_data_2 = ram_word(apipe_2[1]);
  assign mem_rd_data_3 = ram_word(apipe_3[2]);

  port2_read_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(1), .MAX_WAIT(8)) d1 (
    .clk(clk), .reset_n(reset_n),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt_1),
    .vga_rd_valid(vga_rd_valid_1), .vga_rd_data(vga_rd_data_1),
    .aud_req(aud_req), .aud_addr(aud_addr), .aud_gnt(aud_gnt_1),
    .aud_rd_valid(aud_rd_valid_1), .aud_rd_data(aud_rd_data_1),
    .mem_addr(mem_addr_1), .mem_rd_data(mem_rd_data_1), .aud_forced(aud_forced_1));

  port2_read_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(2), .MAX_WAIT(8)) d2 (
    .clk(clk), .reset_n(reset_n),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt_2),
    .vga_rd_valid(vga_rd_valid_2), .vga_rd_data(vga_rd_data_2),
    .aud_req(aud_req), .aud_addr(aud_addr), .aud_gnt(aud_gnt_2),
    .aud_rd_valid(aud_rd_valid_2), .aud_rd_data(aud_rd_data_2),
    .mem_addr(mem_addr_2), .mem_rd_data(mem_rd_data_2), .aud_forced(aud_forced_2));

  port2_read_scheduler #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(3), .MAX_WAIT(8)) d3 (
    .clk(clk), .reset_n(reset_n),
    .vga_req(vga_req), .vga_addr(vga_addr), .vga_gnt(vga_gnt_3),
    .vga_rd_valid(vga_rd_valid_3), .vga_rd_data(vga_rd_data_3),
    .aud_req(aud_req), .aud_addr(aud_addr), .aud_gnt(aud_gnt_3),
    .aud_rd_valid(aud_rd_valid_3), .aud_rd_data(aud_rd_data_3),
    .mem_addr(mem_addr_3), .mem_rd_data(mem_rd_data_3), .aud_forced(aud_forced_3));

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle's requests just after the edge, then wait for mid-cycle.
  task automatic apply_stimulus(input logic vr, input logic [ADDR_W-1:0] va,
                                input logic ar, input logic [ADDR_W-1:0] aa);
    @(posedge clk);
    #1;
    vga_req  = vr;
    vga_addr = va;
    aud_req  = ar;
    aud_addr = aa;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, 1'b0, '0);
  endtask

  task automatic check_quiet(input string tag);
    check_output({tag, "_valid1"}, {vga_rd_valid_1, aud_rd_valid_1}, 0);
    check_output({tag, "_valid2"}, {vga_rd_valid_2, aud_rd_valid_2}, 0);
    check_output({tag, "_valid3"}, {vga_rd_valid_3, aud_rd_valid_3}, 0);
    check_output({tag, "_forced"}, {aud_forced_1, aud_forced_2, aud_forced_3}, 0);
  endtask

  initial begin
    logic                  src;
    logic [ADDR_W-1:0]     a;

    // Requests held high during reset must not be granted.
    reset_n  = 1'b0;
    vga_req  = 1'b1;
    aud_req  = 1'b1;
    vga_addr = 18'h00ABC;
    aud_addr = 18'h00DEF;
    repeat (2) @(negedge clk);
    check_output("rst_gnt", {vga_gnt_1, aud_gnt_1, vga_gnt_3, aud_gnt_3}, 0);
    check_quiet("rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    vga_req = 1'b0;
    aud_req = 1'b0;
    @(negedge clk);
    check_output("rst_mem_addr", mem_addr_1, 0);
    check_output("rst_gnt_idle", {vga_gnt_1, aud_gnt_1}, 0);
    check_quiet("rst_idle");

    // Audio only, RD_LATENCY=1.
    for (int c = 1; c <= 5; c++) begin
      apply_stimulus(1'b0, '0, c <= 3, 18'h00100);
      check_output($sformatf("aud_only_gnt_c%0d", c), aud_gnt_1, c <= 3);
      check_output($sformatf("aud_only_addr_c%0d", c), mem_addr_1, 18'h00100);
      check_output($sformatf("aud_only_rv_c%0d", c), aud_rd_valid_1, c >= 2 && c <= 4);
      check_output($sformatf("aud_only_vrv_c%0d", c), vga_rd_valid_1, 0);
      if (c >= 2 && c <= 4)
        check_output($sformatf("aud_only_data_c%0d", c), aud_rd_data_1, ram_word(18'h00100));
    end
    idle(3);

    // Simultaneous requests: VGA wins.
    apply_stimulus(1'b1, 18'h00200, 1'b1, 18'h00300);
    check_output("simul_vga_gnt", vga_gnt_1, 1);
    check_output("simul_aud_gnt", aud_gnt_1, 0);
    check_output("simul_addr", mem_addr_1, 18'h00200);
    apply_stimulus(1'b0, '0, 1'b0, '0);
    check_output("simul_vrv1", vga_rd_valid_1, 1);
    check_output("simul_vdata1", vga_rd_data_1, ram_word(18'h00200));
    check_output("simul_arv1", aud_rd_valid_1, 0);
    check_output("simul_vrv2_early", vga_rd_valid_2, 0);
    apply_stimulus(1'b0, '0, 1'b0, '0);
    check_output("simul_vrv1_done", vga_rd_valid_1, 0);
    check_output("simul_vrv2", vga_rd_valid_2, 1);
    idle(3);

    // Starvation override under continuous VGA traffic.
    for (int c = 1; c <= 11; c++) begin
      apply_stimulus(1'b1, 18'h00400, c <= 9, 18'h00500);
      check_output($sformatf("starve_agnt_c%0d", c), aud_gnt_1, c == 9);
      check_output($sformatf("starve_vgnt_c%0d", c), vga_gnt_1, c != 9);
      check_output($sformatf("starve_forced_c%0d", c), aud_forced_1, c == 10);
      if (c == 9) check_output("starve_addr", mem_addr_1, 18'h00500);
      if (c == 10) check_output("starve_arv", aud_rd_valid_1, 1);
      if (c == 10) check_output("starve_adata", aud_rd_data_1, ram_word(18'h00500));
    end
    idle(4);

    // Withdrawn request restarts the wait count.
    for (int c = 1; c <= 17; c++) begin
      apply_stimulus(1'b1, 18'h00600, (c != 6) && (c <= 15), 18'h00700);
      check_output($sformatf("withdraw_agnt_c%0d", c), aud_gnt_1, c == 15);
      check_output($sformatf("withdraw_forced_c%0d", c), aud_forced_1, c == 16);
    end
    idle(4);

    // Alternating grants at RD_LATENCY=3.
    for (int k = 0; k <= 10; k++) begin
      if (k < 8)
        apply_stimulus(k % 2 == 0, 18'h01000 + 18'(k), k % 2 == 1, 18'h02000 + 18'(k));
      else
        apply_stimulus(1'b0, '0, 1'b0, '0);
      if (k < 8)
        check_output($sformatf("alt_gnt_k%0d", k), {vga_gnt_3, aud_gnt_3},
                     (k % 2 == 0) ? 2'b10 : 2'b01);
      if (k >= 3 && k - 3 < 8) begin
        src = ((k - 3) % 2 == 1);
        a   = src ? 18'h02000 + 18'(k - 3) : 18'h01000 + 18'(k - 3);
        check_output($sformatf("alt_valid_k%0d", k), {vga_rd_valid_3, aud_rd_valid_3},
                     src ? 2'b01 : 2'b10);
        check_output($sformatf("alt_data_k%0d", k), src ? aud_rd_data_3 : vga_rd_data_3,
                     ram_word(a));
      end else begin
        check_output($sformatf("alt_valid_k%0d", k), {vga_rd_valid_3, aud_rd_valid_3}, 0);
      end
    end
    idle(4);

    // Reset pulse while two reads are in flight.
    apply_stimulus(1'b1, 18'h03000, 1'b0, '0);
    apply_stimulus(1'b0, '0, 1'b1, 18'h03001);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    aud_req = 1'b0;
    @(negedge clk);
    check_quiet("midrst_low");
    check_output("midrst_gnt", {vga_gnt_2, aud_gnt_2}, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    check_quiet("midrst_c4");
    check_output("midrst_addr", mem_addr_2, 0);
    apply_stimulus(1'b0, '0, 1'b0, '0);
    check_quiet("midrst_c5");
    apply_stimulus(1'b0, '0, 1'b0, '0);
    check_quiet("midrst_c6");
    check_output("midrst_addr_c6", mem_addr_2, 0);
    apply_stimulus(1'b1, 18'h03100, 1'b0, '0);
    check_output("midrst_new_gnt", vga_gnt_2, 1);
    apply_stimulus(1'b0, '0, 1'b0, '0);
    check_output("midrst_new_v1", vga_rd_valid_1, 1);
    check_output("midrst_new_v2_early", vga_rd_valid_2, 0);
    apply_stimulus(1'b0, '0, 1'b0, '0);
    check_output("midrst_new_v2", vga_rd_valid_2, 1);
    check_output("midrst_new_d2", vga_rd_data_2, ram_word(18'h03100));
    check_output("midrst_hold_addr", mem_addr_2, 18'h03100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/port2_read_scheduler.md
# port2_read_scheduler

Cycle-by-cycle arbiter for the shared read-only memory port 2.
- Two requesters share the port: the VGA pixel fetcher, which has priority, and the audio mixer sample fetcher, which is secondary.
- Issues at most one read per cycle and tracks each in-flight read with a source tag through the fixed RAM read latency.
- Returns a per-requester data-valid strobe.
- Prevents audio starvation with a bounded-wait override, so the mixer can always keep the codec FIFO fed while VGA is streaming.

## Interface
Parameters:
- ADDR_W, 18, memory word address width
- DATA_W, 16, read data width
- RD_LATENCY, 1, cycles from the grant cycle to the cycle data is on mem_rd_data (1..4)
- MAX_WAIT, 8, consecutive denied audio-request cycles before audio is forced (1..255)

Ports:
- clk  in  1  system clock (CLOCK_50 domain); the only clock
- reset_n  in  1  asynchronous, active-low reset
- vga_req  in  1  VGA read request; held with vga_addr until vga_gnt
- vga_addr  in  ADDR_W  VGA read address
- vga_gnt  out  1  VGA request accepted this cycle (combinational)
- vga_rd_valid  out  1  vga_rd_data valid this cycle
- vga_rd_data  out  DATA_W  read data to VGA
- aud_req  in  1  audio read request; held with aud_addr until aud_gnt
- aud_addr  in  ADDR_W  audio read address
- aud_gnt  out  1  audio request accepted this cycle (combinational)
- aud_rd_valid  out  1  aud_rd_data valid this cycle
- aud_rd_data  out  DATA_W  read data to audio mixer
- mem_addr  out  ADDR_W  address to memory port 2
- mem_rd_data  in  DATA_W  data from memory port 2
- aud_forced  out  1  one-cycle pulse: audio granted by starvation override

## Operation
Grant rule, evaluated each cycle:
- force = aud_req && (wait_cnt == MAX_WAIT).
- aud_gnt = aud_req && (!vga_req || force).
- vga_gnt = vga_req && !aud_gnt.
- Never both grants in the same cycle.

wait_cnt register, 8 bits:
- Increments when aud_req && !aud_gnt, saturating at MAX_WAIT.
- Clears to 0 when aud_gnt is high or aud_req is low.

mem_addr:
- Combinational: the granted requester's address when a grant is made.
- Otherwise last_addr, a register updated on every grant, so the RAM address is stable when idle.

Tag pipeline:
- RD_LATENCY stages, each {valid, src}, with src 0 = VGA and 1 = audio.
- Stage 0 is loaded each cycle with {vga_gnt|aud_gnt, aud_gnt}.
- Final stage drives the outputs: vga_rd_valid = valid && !src, aud_rd_valid = valid && src.

Read data:
- vga_rd_data and aud_rd_data both pass mem_rd_data through.
- They are meaningful only while the matching valid is high.

aud_forced = force, registered so it pulses in the cycle after the forced grant.

Requester behaviour:
- Dropping req before gnt is legal: no read is issued and wait_cnt clears.
- A requester may reissue in the cycle after gnt; back-to-back grants give one read per cycle.

## Timing
Reset values, all outputs low or zero:
- vga_rd_valid, aud_rd_valid and aud_forced are 0.
- mem_addr is 0 when no req is asserted.
- last_addr, wait_cnt and all tag stages are 0.
- The grants are combinational but gated by the reset state, so they are 0 while reset_n is low.

Latency:
- A grant in cycle N gives rd_valid in cycle N+RD_LATENCY, with data on mem_rd_data in that same cycle.

Throughput: 1 read per cycle total.

Audio worst case:
- Under continuous vga_req, audio is granted within MAX_WAIT+1 cycles of asserting aud_req.

VGA worst case: one lost cycle per forced audio grant.

Reset asserted mid-operation:
- All tags clear asynchronously and in-flight reads are discarded.
- No rd_valid appears after reset deasserts unless a new grant is made.

## Test plan
- Audio only: aud_req=1 with aud_addr=0x00100 for 3 cycles at RD_LATENCY=1.
  - Required: aud_gnt=1 each cycle, mem_addr=0x00100, aud_rd_valid=1 in cycles 2–4, vga_rd_valid=0 throughout.
- Simultaneous requests: both requesters asserted in the same cycle with wait_cnt=0.
  - Required: vga_gnt=1, aud_gnt=0, and vga_rd_valid exactly 1 cycle later.
- Starvation override: vga_req held high continuously, aud_req held high, MAX_WAIT=8.
  - Required: aud_gnt=1 in cycle 9, aud_forced pulses in cycle 10, vga_gnt=0 in cycle 9 only, wait_cnt back to 0.
- Request withdrawn: aud_req high for 5 cycles while VGA is busy, then dropped for 1 cycle, then reasserted.
  - Required: wait_cnt restarts from 0 and the forced grant comes 9 cycles after reassertion.
- Latency tagging: RD_LATENCY=3, alternating VGA and audio grants on every cycle.
  - Required: valids alternate starting 3 cycles after the first grant and are never both high; each data word matches the model RAM at the granted address.
- Reset mid-flight: RD_LATENCY=2, reset_n pulsed low 1 cycle after two grants.
  - Required: no rd_valid for either grant, mem_addr=0, outputs 0 until a new request arrives.
